// File: rtl/smvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : smvm_pkg
//  Purpose : Shared types and helpers for the sparse-matrix x dense-vector
//            streaming engine: input parser states, 64-bit word field
//            positions and the bus byte-order swap.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package smvm_pkg;

  // Input parser phases: header word, N vector words, M matrix entries.
  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_VEC = 2'd1,
    ST_ENT = 2'd2
  } state_t;

  // Field positions inside a reassembled 64-bit logical word.
  localparam int HDR_N_MSB    = 63;
  localparam int HDR_N_LSB    = 32;
  localparam int HDR_M_MSB    = 31;
  localparam int HDR_M_LSB    = 0;
  localparam int ENT_LAST_BIT = 63;
  localparam int ENT_COL_MSB  = 47;
  localparam int ENT_COL_LSB  = 32;
  localparam int VAL_MSB      = 31;
  localparam int VAL_LSB      = 0;

  // Bus beats carry each 32-bit half with its bytes reversed; the swap is
  // its own inverse, so the same function serves both directions.
  function automatic logic [31:0] byte_swap32(input logic [31:0] b);
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/smvm_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : smvm_result_fifo
//  Purpose : Synchronous show-ahead FIFO holding row results (64-bit sum plus
//            a last-of-matrix tag in the MSB).
//  Ports   : clk, rst (async, active-low)
//            push / push_data : write side
//            pop  / pop_data  : read side, pop_data valid while !empty
//            empty, count     : occupancy status
//  Rev     : 1.0  initial release
// ============================================================================
module smvm_result_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 65
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   used;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full     = (used == FULL_COUNT);
  assign empty    = (used == '0);
  assign count    = used;
  assign do_pop   = pop & ~empty;
  // A write into a full FIFO is accepted only when a read frees a slot.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/smvm_convert.sv
`default_nettype none
// ============================================================================
//  Module  : smvm_convert
//  Purpose : Streaming sparse-matrix x dense-vector engine. Parses a header,
//            loads x, then multiplies row-major entries against x and emits
//            one signed 64-bit sum per row as two byte-swapped 32-bit beats.
//  Ports   : clk, rst (async, active-low)
//            M_AXIS_Recive_*  : input stream (tdata/tvalid used, tready out)
//            S_AXIS_Send_*    : output stream (tdata/tkeep/tlast/tvalid out)
//            axi_send_fifo_almost_full_0 : holds off starting a new result
//            other almost_* / tkeep / tlast inputs are status only, unused
//  Rev     : 1.0  initial release
// ============================================================================
module smvm_convert #(
  parameter int VEC_AW      = 12,
  parameter int RES_FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_receive_fifo_almost_empty_0,
  input  logic        axi_receive_fifo_almost_full_0,
  input  logic [31:0] M_AXIS_Recive_tdata,
  input  logic [3:0]  M_AXIS_Recive_tkeep,
  input  logic        M_AXIS_Recive_tlast,
  output logic        M_AXIS_Recive_tready,
  input  logic        M_AXIS_Recive_tvalid,
  input  logic        axi_send_fifo_almost_empty_0,
  input  logic        axi_send_fifo_almost_full_0,
  output logic [31:0] S_AXIS_Send_tdata,
  output logic [3:0]  S_AXIS_Send_tkeep,
  output logic        S_AXIS_Send_tlast,
  input  logic        S_AXIS_Send_tready,
  output logic        S_AXIS_Send_tvalid
);

  import smvm_pkg::*;

  localparam int unsigned VEC_DEPTH = 32'd1 << VEC_AW;
  localparam int          RES_DEPTH = 1 << RES_FIFO_AW;
  // Stop accepting input with four slots left so entries already in the
  // multiply/accumulate pipeline always find room.
  localparam logic [RES_FIFO_AW:0] READY_LIMIT = (RES_FIFO_AW + 1)'(RES_DEPTH - 4);

  // ---------------------------------------------------------------- input side
  state_t      state;
  state_t      state_nxt;
  logic        low_phase;   // 0: next beat is a high half, 1: low half
  logic [31:0] hi_word;
  logic [31:0] lo_word;
  logic [63:0] word;
  logic [31:0] n_words;
  logic [31:0] m_words;
  logic [31:0] word_idx;
  logic        ready_en;
  logic        in_ready;
  logic        beat_fire;
  logic        word_fire;
  logic [RES_FIFO_AW:0] fifo_count;

  assign lo_word   = byte_swap32(M_AXIS_Recive_tdata);
  assign word      = {hi_word, lo_word};
  assign in_ready  = ready_en & (fifo_count < READY_LIMIT);
  assign beat_fire = in_ready & M_AXIS_Recive_tvalid;
  assign word_fire = beat_fire & low_phase;

  assign M_AXIS_Recive_tready = in_ready;

  always_comb begin
    state_nxt = state;
    if (word_fire) begin
      case (state)
        ST_HDR: begin
          if (word[HDR_N_MSB:HDR_N_LSB] != '0)      state_nxt = ST_VEC;
          else if (word[HDR_M_MSB:HDR_M_LSB] != '0) state_nxt = ST_ENT;
          else                                      state_nxt = ST_HDR;
        end
        ST_VEC: begin
          if (word_idx == n_words - 1) state_nxt = (m_words != '0) ? ST_ENT : ST_HDR;
        end
        ST_ENT: begin
          if (word_idx == m_words - 1) state_nxt = ST_HDR;
        end
        default: state_nxt = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_HDR;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en  <= 1'b0;
      low_phase <= 1'b0;
      hi_word   <= '0;
      n_words   <= '0;
      m_words   <= '0;
      word_idx  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (beat_fire) low_phase <= ~low_phase;
      if (beat_fire && !low_phase) hi_word <= lo_word;
      if (word_fire) begin
        case (state)
          ST_HDR: begin
            n_words  <= word[HDR_N_MSB:HDR_N_LSB];
            m_words  <= word[HDR_M_MSB:HDR_M_LSB];
            word_idx <= '0;
          end
          ST_VEC:  word_idx <= (word_idx == n_words - 1) ? '0 : word_idx + 1;
          ST_ENT:  word_idx <= word_idx + 1;
          default: word_idx <= '0;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- x memory
  logic [31:0] x_mem [0:VEC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (word_fire && state == ST_VEC && word_idx < VEC_DEPTH) begin
      x_mem[word_idx[VEC_AW-1:0]] <= lo_word;
    end
  end

  // ---------------------------------------------------- entry capture (stage 0)
  logic        ent_valid;
  logic [15:0] ent_col;
  logic [31:0] ent_val;
  logic        ent_row_last;
  logic        ent_final;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid    <= 1'b0;
      ent_col      <= '0;
      ent_val      <= '0;
      ent_row_last <= 1'b0;
      ent_final    <= 1'b0;
    end else begin
      ent_valid <= word_fire && (state == ST_ENT);
      if (word_fire) begin
        ent_col      <= word[ENT_COL_MSB:ENT_COL_LSB];
        ent_val      <= word[VAL_MSB:VAL_LSB];
        ent_row_last <= word[ENT_LAST_BIT];
        ent_final    <= (word_idx == m_words - 1);
      end
    end
  end

  // ------------------------------------------------ lookup + multiply (stage 1)
  logic [31:0] x_word;
  logic        col_hit;
  logic [63:0] full_prod;
  logic        prod_valid;
  logic        prod_flush;
  logic        prod_final;
  logic [63:0] prod;

  assign x_word  = x_mem[ent_col[VEC_AW-1:0]];
  // Columns beyond N, or beyond what x memory can hold, contribute nothing.
  assign col_hit = ({16'd0, ent_col} < n_words) && ({16'd0, ent_col} < VEC_DEPTH);
  assign full_prod = $signed({{32{ent_val[31]}}, ent_val}) *
                     $signed({{32{x_word[31]}}, x_word});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_valid <= 1'b0;
      prod_flush <= 1'b0;
      prod_final <= 1'b0;
      prod       <= '0;
    end else begin
      prod_valid <= ent_valid;
      prod_flush <= ent_row_last | ent_final;
      prod_final <= ent_final;
      prod       <= col_hit ? full_prod : 64'd0;
    end
  end

  // ------------------------------------------------------ accumulate (stage 2)
  logic [63:0] acc;
  logic [63:0] acc_sum;
  logic        res_push;

  assign acc_sum  = acc + prod;
  assign res_push = prod_valid & prod_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            acc <= '0;
    else if (res_push)   acc <= '0;
    else if (prod_valid) acc <= acc_sum;
  end

  // ------------------------------------------------------------ result FIFO
  logic [64:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_pop;

  smvm_result_fifo #(
    .ADDR_W (RES_FIFO_AW),
    .DATA_W (65)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data ({prod_final, acc_sum}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ------------------------------------------------------------ output side
  logic        out_valid;
  logic        out_lo;        // 1 while the low beat is being presented
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] lo_hold;
  logic        last_hold;
  logic        out_free;

  // The output register is free when idle or when its low beat is leaving.
  assign out_free = ~out_valid | (S_AXIS_Send_tready & out_lo);
  assign fifo_pop = out_free & ~fifo_empty & ~axi_send_fifo_almost_full_0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_lo    <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      lo_hold   <= '0;
      last_hold <= 1'b0;
    end else if (out_free) begin
      if (fifo_pop) begin
        out_valid <= 1'b1;
        out_lo    <= 1'b0;
        out_data  <= byte_swap32(fifo_data[63:32]);
        out_last  <= 1'b0;
        lo_hold   <= fifo_data[31:0];
        last_hold <= fifo_data[64];
      end else begin
        out_valid <= 1'b0;
        out_lo    <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (S_AXIS_Send_tready) begin
      // High beat taken; the low beat follows without rechecking almost_full.
      out_lo   <= 1'b1;
      out_data <= byte_swap32(lo_hold);
      out_last <= last_hold;
    end
  end

  assign S_AXIS_Send_tvalid = out_valid;
  assign S_AXIS_Send_tdata  = out_data;
  assign S_AXIS_Send_tlast  = out_last;
  assign S_AXIS_Send_tkeep  = 4'hF;

  logic unused_status;
  assign unused_status = ^{axi_receive_fifo_almost_empty_0, axi_receive_fifo_almost_full_0,
                           M_AXIS_Recive_tkeep, M_AXIS_Recive_tlast,
                           axi_send_fifo_almost_empty_0};

endmodule
`default_nettype wire

// File: tb/tb_smvm_convert.sv
`default_nettype none
// ============================================================================
//  Module  : tb_smvm_convert
//  Purpose : Self-checking bench for smvm_convert. Matrices are described as
//            plain lists; a reference model computes the row sums and the
//            expected output beats, which are compared with the captured
//            output stream.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_smvm_convert;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        send_af;

  int total = 0;
  int bad   = 0;
  int in_beats = 0;

  logic [32:0] got[$];    // {tlast, tdata} of every transferred output beat
  logic [32:0] want[$];
  logic [31:0] beats[$];
  int          mx_x[$];
  int          mx_col[$];
  int          mx_val[$];
  bit          mx_last[$];

  always #5 clk = ~clk;

  smvm_convert dut (
    .clk                             (clk),
    .rst                             (rst),
    .axi_receive_fifo_almost_empty_0 (1'b0),
    .axi_receive_fifo_almost_full_0  (1'b0),
    .M_AXIS_Recive_tdata             (in_data),
    .M_AXIS_Recive_tkeep             (4'hF),
    .M_AXIS_Recive_tlast             (1'b0),
    .M_AXIS_Recive_tready            (in_ready),
    .M_AXIS_Recive_tvalid            (in_valid),
    .axi_send_fifo_almost_empty_0    (1'b0),
    .axi_send_fifo_almost_full_0     (send_af),
    .S_AXIS_Send_tdata               (out_data),
    .S_AXIS_Send_tkeep               (out_keep),
    .S_AXIS_Send_tlast               (out_last),
    .S_AXIS_Send_tready              (out_ready),
    .S_AXIS_Send_tvalid              (out_valid)
  );

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got.push_back({out_last, out_data});
  end

  function automatic logic [31:0] swap(input logic [31:0] b);
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
  endfunction

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic add_word(input logic [63:0] w);
    beats.push_back(swap(w[63:32]));
    beats.push_back(swap(w[31:0]));
  endtask

  // Reference model: build the input beats for one matrix and the expected
  // output beats from the row sums.
  task automatic emit_matrix(input int n);
    longint acc;
    longint p;
    int     m;
    m = mx_col.size();
    add_word({32'(n), 32'(m)});
    for (int i = 0; i < n; i++) add_word({$urandom(), mx_x[i]});
    acc = 0;
    for (int k = 0; k < m; k++) begin
      add_word({mx_last[k], 15'($urandom()), 16'(mx_col[k]), mx_val[k]});
      p = 0;
      if (mx_col[k] < n) p = longint'(mx_x[mx_col[k]]) * longint'(mx_val[k]);
      acc += p;
      if (mx_last[k] || k == m - 1) begin
        want.push_back({1'b0, swap(acc[63:32])});
        want.push_back({(k == m - 1), swap(acc[31:0])});
        acc = 0;
      end
    end
    mx_x.delete(); mx_col.delete(); mx_val.delete(); mx_last.delete();
  endtask

  task automatic add_entry(input int col, input int val, input bit last);
    mx_col.push_back(col); mx_val.push_back(val); mx_last.push_back(last);
  endtask

  task automatic rand_matrix(input int n, input int m);
    for (int i = 0; i < n; i++) mx_x.push_back(int'($urandom()));
    for (int k = 0; k < m; k++)
      add_entry(int'($urandom_range(0, n + 2)), int'($urandom()), ($urandom_range(0, 2) == 0));
    emit_matrix(n);
  endtask

  task automatic send_all();
    int guard;
    foreach (beats[i]) begin
      in_data  = beats[i];
      in_valid = 1'b1;
      guard    = 0;
      @(negedge clk);
      while (!in_ready && guard < 2000) begin @(negedge clk); guard++; end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL in_accept beat=%0d tready=%b required=1", i, in_ready);
        break;
      end
      @(posedge clk); in_beats++; #1;
    end
    in_valid = 1'b0;
    beats.delete();
  endtask

  task automatic wait_results();
    int guard = 0;
    while (got.size() < want.size() && guard < 3000) begin @(negedge clk); guard++; end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_results(input string name);
    wait_results();
    total++;
    if (got.size() != want.size()) begin
      bad++;
      $display("FAIL %s beat_count got=%0d required=%0d", name, got.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== want[i]) begin
        bad++;
        $display("FAIL %s beat%0d got last=%b data=%h required last=%b data=%h",
                 name, i, got[i][32], got[i][31:0], want[i][32], want[i][31:0]);
      end
    end
    got.delete(); want.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; send_af = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b required=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b required=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b required=0", out_last); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h required=0", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL tkeep got=%h required=f", out_keep); end
    align(); rst = 1'b1;
    align();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_tready got=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [32:0] lit [4];
    lit = '{{1'b0, 32'h0}, {1'b0, 32'h07000000}, {1'b0, 32'h0}, {1'b1, 32'h02000000}};
    got.delete(); align();
    mx_x.push_back(3); mx_x.push_back(-2);
    add_entry(0, 5, 1'b0); add_entry(1, 4, 1'b1); add_entry(1, -1, 1'b1);
    emit_matrix(2);
    send_all();
    wait_results();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got.size() || got[i] !== lit[i]) begin
        bad++;
        $display("FAIL basic_literal beat%0d got=%h required=%h", i,
                 (i < got.size()) ? got[i] : 33'h0, lit[i]);
      end
    end
    check_results("basic");
  endtask

  task automatic test_negative();
    int lat = 0;
    got.delete(); align();
    mx_x.push_back(-1); add_entry(0, 7, 1'b1);
    emit_matrix(1);
    send_all();
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 3) begin bad++; $display("FAIL latency got=%0d required=3", lat); end
    total++; if (out_data !== 32'hFFFFFFFF || out_last !== 1'b0) begin
      bad++; $display("FAIL neg_high got=%h/%b required=ffffffff/0", out_data, out_last); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hF9FFFFFF || out_last !== 1'b1) begin
      bad++; $display("FAIL neg_low got=%b/%h/%b required=1/f9ffffff/1", out_valid, out_data, out_last); end
    check_results("negative");
  endtask

  task automatic test_empty_oob();
    got.delete(); align();
    send_af = 1'b1;
    mx_x.push_back(6); mx_x.push_back(-9);
    add_entry(0, 0, 1'b1); add_entry(5, 123, 1'b1); add_entry(1, 11, 1'b1);
    emit_matrix(2);
    send_all();
    repeat (10) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL almost_full_hold tvalid=%b required=0", out_valid); end
    align(); send_af = 1'b0;
    check_results("empty_oob");
  endtask

  task automatic test_backpressure();
    int          drop_entries = -1;
    int          guard = 0;
    logic [31:0] held;
    got.delete(); align();
    out_ready = 1'b0; in_beats = 0;
    mx_x.push_back(int'($urandom()));
    for (int k = 0; k < 20; k++) add_entry(0, int'($urandom()), 1'b1);
    emit_matrix(1);
    fork
      send_all();
      begin
        @(negedge clk);
        while (!out_valid && guard < 200) begin @(negedge clk); guard++; end
        held = out_data;
        for (int c = 0; c < 30; c++) begin
          if (!in_ready && drop_entries < 0) drop_entries = (in_beats - 4) / 2;
          total++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h required=1/%h", c, out_valid, out_data, held);
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    total++;
    if (drop_entries < 13 || drop_entries > 16) begin
      bad++; $display("FAIL tready_drop entries_accepted=%0d required=13..16", drop_entries);
    end
    check_results("backpressure");
  endtask

  task automatic test_reset_mid();
    got.delete(); align();
    rand_matrix(2, 0);
    beats.delete(); want.delete();
    mx_x.push_back(4); mx_x.push_back(5);
    for (int k = 0; k < 5; k++) add_entry(k % 2, 3, 1'b0);
    emit_matrix(2);
    while (beats.size() > 11) void'(beats.pop_back());   // stop after a lone high beat
    want.delete();
    send_all();
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst got tready=%b tvalid=%b required=0/0", in_ready, out_valid); end
    align(); rst = 1'b1; got.delete();
    align();
    mx_x.push_back(2); add_entry(0, 9, 1'b1);
    emit_matrix(1);
    send_all();
    wait_results();
    total++; if (got.size() < 2 || got[1] !== {1'b1, 32'h12000000}) begin
      bad++; $display("FAIL fresh_result got_beats=%0d low=%h required=112000000", got.size(),
                      (got.size() > 1) ? got[1] : 33'h0); end
    check_results("reset_mid");
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    got.delete(); align();
    rand_matrix(3, 4);
    rand_matrix(0, 3);
    rand_matrix(2, 0);
    rand_matrix(5, 7);
    fork
      begin send_all(); done = 1'b1; end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 1) == 1); end
        out_ready = 1'b1;
      end
    join
    check_results("back_to_back");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      got.delete(); align();
      rand_matrix(int'($urandom_range(1, 8)), int'($urandom_range(1, 12)));
      send_all();
      check_results("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_empty_oob();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/smvm_convert.md
Name: smvm_convert

Overview:
- Streaming sparse-matrix × dense-vector engine between the DMA receive FIFO (AXI-Stream in) and the DMA send FIFO (AXI-Stream out).
- The input stream carries, in order: a header, the dense vector x, then matrix entries in row-major order.
- For each row it accumulates value × x[col] and emits one signed 64-bit row sum per row on the output stream.

Parameters:
- VEC_AW, 12, address width of the x memory (depth 2^VEC_AW entries, 32-bit signed each).
- RES_FIFO_AW, 4, address width of the result FIFO (depth 16 × 64-bit).

Ports:
- clk  in  1  single system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- axi_receive_fifo_almost_empty_0  in  1  status only; ignored.
- axi_receive_fifo_almost_full_0  in  1  status only; ignored.
- M_AXIS_Recive_tdata  in  32  input beat.
- M_AXIS_Recive_tkeep  in  4  ignored (always full beats).
- M_AXIS_Recive_tlast  in  1  ignored; framing comes from the header.
- M_AXIS_Recive_tready  out  1  input accept.
- M_AXIS_Recive_tvalid  in  1  input beat valid.
- axi_send_fifo_almost_empty_0  in  1  status only; ignored.
- axi_send_fifo_almost_full_0  in  1  1 = do not start a new result.
- S_AXIS_Send_tdata  out  32  output beat.
- S_AXIS_Send_tkeep  out  4  constant 4'hF.
- S_AXIS_Send_tlast  out  1  marks the low beat of the last row result of a matrix.
- S_AXIS_Send_tready  in  1  output accept.
- S_AXIS_Send_tvalid  out  1  output beat valid.

Behaviour:
- Beat format:
  - Every 64-bit logical word travels as two beats, high half first.
  - Each beat is byte-reversed on the bus: logical = {b[7:0], b[15:8], b[23:16], b[31:24]}.
  - Output uses the identical encoding. A beat transfers on valid & ready.
- Word layouts:
  - Header: [63:32] = N (vector length), [31:0] = M (entry count).
  - Vector word: [31:0] = signed x[i]; [63:32] ignored.
  - Entry word: [63] = row_last, [62:48] reserved, [47:32] = col, [31:0] = signed value.
- State machine: HDR → VEC (N words; skipped if N = 0) → ENT (M words; skipped if M = 0) → HDR.
  - A beat-phase flag selects high/low half. It toggles on every accepted beat and clears on reset.
  - Vector words with index ≥ 2^VEC_AW are accepted and discarded.
- Datapath per entry:
  - Stage 1, on the cycle after the low beat is accepted: x lookup and 32×32 signed multiply, registered. col ≥ N contributes 0.
  - Stage 2: accumulator += product, 64-bit two's complement, wraps silently.
  - On row_last: the sum (including the current product) is pushed to the result FIFO, tagged last if it is entry M−1; the accumulator clears in the same cycle.
  - An empty row is encoded as value 0 with row_last and yields result 0.
  - The final entry without row_last set is still flushed as a result, tagged last.
- Input tready: 1 out of reset unless the result FIFO holds ≥ depth−4 entries (headroom for the in-flight pipeline).
- Output:
  - When the FIFO is non-empty and axi_send_fifo_almost_full_0 = 0, present the high beat, then the low beat; tvalid stays high across both.
  - Each beat is held stable until tready.
  - The almost_full input is only checked before a high beat, never between the two halves.
- Latency: with an empty FIFO and tready = 1, the high beat is valid 3 clocks after the edge accepting the row_last entry's low beat; the low beat follows on the next clock.
- Reset values:
  - M_AXIS_Recive_tready = 0 during reset.
  - S_AXIS_Send_tvalid = 0, S_AXIS_Send_tlast = 0, S_AXIS_Send_tdata = 0.
  - State = HDR, accumulator = 0, FIFO empty, beat-phase = high.
  - Reset mid-stream discards all partial state; the x memory contents are don't-care.

Decomposition:
- smvm_pkg: state enum (HDR/VEC/ENT), word field bit positions, byte_swap32 function.
- One sub-module: smvm_result_fifo (synchronous 65-bit FIFO, data + last tag, with count output).

Test Plan:
- Header N=2, M=3; x=[3, −2]; entries (col0, 5, last=0), (col1, 4, last=1), (col1, −1, last=1):
  - First result 7: beats 0x00000000, 0x07000000, tlast=0.
  - Second result 2: beats 0x00000000, 0x02000000, tlast=1.
- Negative result, x=[−1], entry (0, 7, last=1) → beats 0xFFFFFFFF then 0xF9FFFFFF.
- Empty row (value 0, last=1) and col=5 with N=2 → result 0; no stall.
- S_AXIS_Send_tready held low for 30 cycles during a 20-row stream:
  - M_AXIS_Recive_tready drops by FIFO count 12.
  - No result is lost; results come out in order after release.
- rst pulsed low mid-ENT, then a fresh matrix (N=1, M=1, x=[2], value 9) → a single result 18; no stale output.
- Two back-to-back matrices → tlast only on the final low beat of each.
